// File: rtl/card_dealer.sv
// card_dealer: deals card ranks from a 52-card deck, four of each rank.
//
// The random source is an external free-running counter. Its value mod 13
// picks a starting rank. If that rank is used up, the dealer steps to the
// next rank, one cycle per miss, until it finds one with cards left.
// When DEAL_DELAY is set, each deal waits for a two-second timer handshake
// before the card is presented.
//
// Ports:
//   clk_50M      in   system clock, rising edge
//   i_Reset      in   synchronous active-high reset
//   i_Count      in   free-running counter value (random source)
//   i_Draw       in   deal request (level or pulse)
//   i_Shuffle    in   refill the full deck
//   i_TwoSec     in   two-second timer expired (one-cycle pulse)
//   o_TwoSec     out  two-second timer start request, held until acknowledged
//   o_Card       out  dealt rank 1..13, held between deals
//   o_Valid      out  one-cycle pulse, o_Card holds a new card
//   o_Busy       out  a deal is in progress
//   o_Empty      out  deck is empty
//   o_Remaining  out  cards left in the deck, 0..52
module card_dealer #(
  parameter int WIDTH      = 12,
  parameter int DEAL_DELAY = 1
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_Draw,
  input  logic             i_Shuffle,
  input  logic             i_TwoSec,
  output logic             o_TwoSec,
  output logic [3:0]       o_Card,
  output logic             o_Valid,
  output logic             o_Busy,
  output logic             o_Empty,
  output logic [5:0]       o_Remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DELAY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cand_reg, cand_next;
  logic [3:0]  card_reg, card_next;
  logic [5:0]  remaining_reg;
  logic [2:0]  cnt_reg [1:13];
  logic [3:0]  rand_rank;
  logic        take;
  logic        refill;

  // Starting rank taken from the whole counter value, not just its low bits.
  assign rand_rank = 4'(i_Count % WIDTH'(13)) + 4'd1;

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_reg     <= IDLE;
      cand_reg      <= 4'd1;
      card_reg      <= 4'd0;
      remaining_reg <= 6'd52;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      card_reg  <= card_next;
      if (refill)
        remaining_reg <= 6'd52;
      else if (take)
        remaining_reg <= remaining_reg - 6'd1;
    end
  end

  // One remaining-count register per rank.
  generate
    for (genvar gi = 1; gi <= 13; gi++) begin : g_rank
      always_ff @(posedge clk_50M) begin
        if (i_Reset || refill)
          cnt_reg[gi] <= 3'd4;
        else if (take && (cand_reg == 4'(gi)))
          cnt_reg[gi] <= cnt_reg[gi] - 3'd1;
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    card_next  = card_reg;
    take       = 1'b0;
    refill     = 1'b0;
    case (state_reg)
      IDLE: begin
        // A shuffle wins over a draw in the same cycle.
        if (i_Shuffle) begin
          refill = 1'b1;
        end else if (i_Draw && (remaining_reg != 6'd0)) begin
          cand_next  = rand_rank;
          state_next = PROBE;
        end
      end
      PROBE: begin
        if (cnt_reg[cand_reg] != 3'd0) begin
          take       = 1'b1;
          card_next  = cand_reg;
          state_next = (DEAL_DELAY != 0) ? DELAY : DONE;
        end else begin
          // The deck is non-empty here, so the walk ends within 12 misses.
          cand_next = (cand_reg == 4'd13) ? 4'd1 : cand_reg + 4'd1;
        end
      end
      DELAY: begin
        if (i_TwoSec)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All status outputs decode directly from registered state.
  assign o_TwoSec    = (state_reg == DELAY);
  assign o_Valid     = (state_reg == DONE);
  assign o_Busy      = (state_reg != IDLE);
  assign o_Card      = card_reg;
  assign o_Remaining = remaining_reg;
  assign o_Empty     = (remaining_reg == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- DUT0: no pacing ----------------
  logic        reset0 = 1'b1, drw0 = 1'b0, shuf0 = 1'b0, tsi0 = 1'b0;
  logic [11:0] count0 = '0;
  logic        tso0, val0, busy0, empty0;
  logic [3:0]  card0;
  logic [5:0]  rem0;

  card_dealer #(.WIDTH(12), .DEAL_DELAY(0)) dut0 (
    .clk_50M(clk), .i_Reset(reset0), .i_Count(count0), .i_Draw(drw0),
    .i_Shuffle(shuf0), .i_TwoSec(tsi0), .o_TwoSec(tso0), .o_Card(card0),
    .o_Valid(val0), .o_Busy(busy0), .o_Empty(empty0), .o_Remaining(rem0)
  );

  // ---------------- DUT1: paced by two-second timer ----------------
  logic        reset1 = 1'b1, drw1 = 1'b0, shuf1 = 1'b0, tsi1 = 1'b0;
  logic [11:0] count1 = '0;
  logic        tso1, val1, busy1, empty1;
  logic [3:0]  card1;
  logic [5:0]  rem1;

  card_dealer #(.WIDTH(12), .DEAL_DELAY(1)) dut1 (
    .clk_50M(clk), .i_Reset(reset1), .i_Count(count1), .i_Draw(drw1),
    .i_Shuffle(shuf1), .i_TwoSec(tsi1), .o_TwoSec(tso1), .o_Card(card1),
    .o_Valid(val1), .o_Busy(busy1), .o_Empty(empty1), .o_Remaining(rem1)
  );

  // ---------------- scoreboards ----------------
  typedef struct {
    int card;
    int rem;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   unexp0 = 0, unexp1 = 0;
  int   tally0[16];
  int   exp_rem0 = 52;

  always @(negedge clk) begin
    exp_t e;
    if (val0) begin
      if (q0.size() == 0) begin
        unexp0++;
        chk("dut0_unexpected_valid", 1, 0);
      end else begin
        e = q0.pop_front();
        $display("deal dut0 cyc=%0d card=%0d rem=%0d exp_card=%0d exp_rem=%0d exp_cyc=%0d",
                 cyc, card0, rem0, e.card, e.rem, e.cyc);
        chk("dut0_card", int'(card0), e.card);
        chk("dut0_remaining", int'(rem0), e.rem);
        chk("dut0_latency_cycle", cyc, e.cyc);
        tally0[card0]++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (val1) begin
      if (q1.size() == 0) begin
        unexp1++;
        chk("dut1_unexpected_valid", 1, 0);
      end else begin
        e = q1.pop_front();
        $display("deal dut1 cyc=%0d card=%0d rem=%0d exp_card=%0d exp_rem=%0d exp_cyc=%0d",
                 cyc, card1, rem1, e.card, e.rem, e.cyc);
        chk("dut1_card", int'(card1), e.card);
        chk("dut1_remaining", int'(rem1), e.rem);
        chk("dut1_latency_cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy0) chk("dut0_busy_timeout", 1, 0);
  endtask

  task automatic draw0(input int cnt, input int card, input int misses);
    exp_t e;
    count0 = 12'(cnt);
    drw0   = 1'b1;
    exp_rem0--;
    e.card = card;
    e.rem  = exp_rem0;
    e.cyc  = cyc + 2 + misses;
    q0.push_back(e);
    @(negedge clk);
    drw0 = 1'b0;
    wait_idle0();
  endtask

  task automatic rst0();
    reset0 = 1'b1;
    @(negedge clk);
    reset0 = 1'b0;
    exp_rem0 = 52;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m[14];
    int cnt, c, misses;
    exp_t e;

    for (int i = 0; i < 16; i++) tally0[i] = 0;
    repeat (2) @(negedge clk);

    // Reset state (reset still asserted)
    chk("reset_card", int'(card0), 0);
    chk("reset_valid", int'(val0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_empty", int'(empty0), 0);
    chk("reset_remaining", int'(rem0), 52);
    chk("reset_twosec", int'(tso0), 0);
    chk("reset1_twosec", int'(tso1), 0);
    reset0 = 1'b0;
    reset1 = 1'b0;
    @(negedge clk);

    // 100 mod 13 = 9 -> card 10
    draw0(100, 10, 0);
    chk("draw100_remaining", int'(rem0), 51);
    chk("draw100_card_held", int'(card0), 10);

    // Five draws at count 13: four aces, then a miss walks to 2
    rst0();
    for (int i = 0; i < 4; i++) draw0(13, 1, 0);
    draw0(13, 2, 1);
    chk("five_draws_remaining", int'(rem0), 47);

    // Full deck exhaustion with random counts
    rst0();
    for (int r = 1; r <= 13; r++) m[r] = 4;
    for (int i = 0; i < 16; i++) tally0[i] = 0;
    for (int i = 0; i < 52; i++) begin
      cnt = int'($urandom_range(0, 4095));
      c = (cnt % 13) + 1;
      misses = 0;
      while (m[c] == 0) begin
        c = (c == 13) ? 1 : c + 1;
        misses++;
      end
      m[c]--;
      draw0(cnt, c, misses);
    end
    for (int r = 1; r <= 13; r++) chk($sformatf("rank%0d_dealt", r), tally0[r], 4);
    chk("exhaust_remaining", int'(rem0), 0);
    chk("exhaust_empty", int'(empty0), 1);

    // 53rd draw is ignored
    count0 = 12'd5;
    drw0 = 1'b1;
    @(negedge clk);
    drw0 = 1'b0;
    chk("empty_draw_busy", int'(busy0), 0);
    repeat (4) @(negedge clk);
    chk("empty_draw_busy_later", int'(busy0), 0);
    chk("empty_draw_no_valid", unexp0, 0);

    // Shuffle refills
    shuf0 = 1'b1;
    @(negedge clk);
    shuf0 = 1'b0;
    chk("shuffle_remaining", int'(rem0), 52);
    chk("shuffle_empty", int'(empty0), 0);
    exp_rem0 = 52;

    // Shuffle and draw together: refill, no deal
    draw0(0, 1, 0);
    chk("pre_combo_remaining", int'(rem0), 51);
    count0 = 12'd0;
    shuf0 = 1'b1;
    drw0 = 1'b1;
    @(negedge clk);
    shuf0 = 1'b0;
    drw0 = 1'b0;
    chk("combo_remaining", int'(rem0), 52);
    chk("combo_busy", int'(busy0), 0);
    repeat (4) @(negedge clk);
    chk("combo_no_valid", unexp0, 0);

    // ---------- DUT1: paced deal, 4095 mod 13 = 0 -> ace ----------
    count1 = 12'd4095;
    drw1 = 1'b1;
    @(negedge clk);              // PROBE
    drw1 = 1'b0;
    chk("probe_twosec", int'(tso1), 0);
    chk("probe_busy", int'(busy1), 1);
    @(negedge clk);              // DELAY
    chk("delay_twosec", int'(tso1), 1);
    repeat (10) @(negedge clk);
    chk("delay_twosec_held", int'(tso1), 1);
    chk("delay_busy_held", int'(busy1), 1);
    tsi1 = 1'b1;
    e.card = 1;
    e.rem  = 51;
    e.cyc  = cyc + 1;
    q1.push_back(e);
    @(negedge clk);              // DONE
    tsi1 = 1'b0;
    chk("ack_twosec_low", int'(tso1), 0);
    @(negedge clk);
    chk("after_paced_busy", int'(busy1), 0);

    // Reset in the middle of DELAY
    count1 = 12'd7;
    drw1 = 1'b1;
    @(negedge clk);
    drw1 = 1'b0;
    @(negedge clk);
    chk("delay2_twosec", int'(tso1), 1);
    reset1 = 1'b1;
    @(negedge clk);
    reset1 = 1'b0;
    chk("mid_reset_twosec", int'(tso1), 0);
    chk("mid_reset_busy", int'(busy1), 0);
    chk("mid_reset_remaining", int'(rem1), 52);
    chk("mid_reset_card", int'(card1), 0);
    tsi1 = 1'b1;                 // stray timer pulse while idle
    @(negedge clk);
    tsi1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_reset_no_valid", unexp1, 0);
    chk("mid_reset_idle", int'(busy1), 0);

    chk("dut0_pending_expectations", q0.size(), 0);
    chk("dut1_pending_expectations", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the width of the sampled counter value (WIDTH >= 4).
REQ-002 The block SHALL have parameter DEAL_DELAY, default 1; 1 = each deal paced by the two-second timer handshake, 0 = no pacing.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports:
- clk_50M  in  1  50 MHz system clock, all logic on rising edge.
- i_Reset  in  1  synchronous active-high reset.
- i_Count  in  WIDTH  free-running counter value, used as the random source.
- i_Draw  in  1  deal request from the game FSM, level or pulse.
- i_Shuffle  in  1  restore the full 52-card deck.
- i_TwoSec  in  1  two-second timer expired, one-cycle pulse.
- o_TwoSec  out  1  two-second timer start request, held until acknowledged.
- o_Card  out  4  dealt rank, 1..13 (1 = ace, 11..13 = J/Q/K).
- o_Valid  out  1  one-cycle pulse, o_Card holds a new card.
- o_Busy  out  1  a deal is in progress.
- o_Empty  out  1  no cards remain.
- o_Remaining  out  6  cards left in the deck, 0..52.

Function
REQ-005 The block SHALL keep, per rank 1..13, a 3-bit remaining count in the range 0..4; o_Remaining SHALL equal the sum of these counts.
REQ-006 The FSM SHALL have states IDLE, PROBE, DELAY and DONE; o_Busy SHALL be 1 in every state except IDLE.
REQ-007 In IDLE with i_Shuffle=1, all rank counts SHALL be set to 4 and o_Remaining to 52 at the next edge; i_Draw in the same cycle SHALL be ignored; o_Card SHALL be unchanged.
REQ-008 In IDLE with i_Draw=1, i_Shuffle=0 and o_Empty=0, the block SHALL latch candidate = (i_Count mod 13) + 1, using the full WIDTH-bit unsigned value, and go to PROBE.
REQ-009 In IDLE with i_Draw=1 and o_Empty=1, the request SHALL be ignored: no state change and no o_Valid.
REQ-010 i_Draw and i_Shuffle SHALL be ignored outside IDLE.
REQ-011 In PROBE, if the candidate's count is greater than 0, the block SHALL do all of the following at the next edge:
- decrement that count and o_Remaining by 1;
- load o_Card with the candidate;
- go to DELAY if DEAL_DELAY=1, else DONE.
REQ-012 In PROBE, if the candidate's count is 0, the block SHALL advance the candidate (13 wraps to 1) and stay in PROBE; one cycle per miss; at most 12 misses, since the deck is non-empty.
REQ-013 In DELAY, o_TwoSec SHALL be 1. On i_TwoSec=1 the block SHALL go to DONE, and o_TwoSec SHALL be 0 from that edge. i_TwoSec outside DELAY SHALL be ignored.
REQ-014 In DONE, o_Valid SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-015 Latency with DEAL_DELAY=0 SHALL be: o_Valid high 2 cycles after the accepting edge, plus 1 cycle per PROBE miss.
REQ-016 o_Empty SHALL be 1 exactly when o_Remaining = 0. o_Card SHALL hold its value between o_Valid pulses.

Reset
REQ-017 When i_Reset=1 at an edge, the next state SHALL be as follows, regardless of current state (including mid-DELAY):
- state IDLE; all rank counts 4; o_Remaining = 52;
- o_Card = 0; o_Valid, o_TwoSec, o_Busy and o_Empty = 0.
REQ-018 i_Reset SHALL take priority over all other inputs.

Verification
REQ-019 DEAL_DELAY=0, after reset: i_Count=100, pulse i_Draw -> o_Valid 2 cycles later, o_Card=10, o_Remaining=51.
REQ-020 DEAL_DELAY=0: five draws with i_Count=13 -> four deals of o_Card=1; the fifth gives o_Card=2 with o_Valid one cycle later (3 cycles).
REQ-021 DEAL_DELAY=1: i_Count=4095, i_Draw -> o_TwoSec rises after PROBE and stays high; i_TwoSec pulse 10 cycles later -> o_TwoSec low, o_Valid next cycle, o_Card=1.
REQ-022 52 consecutive draws with random i_Count:
- each rank dealt exactly 4 times; o_Remaining=0, o_Empty=1;
- a 53rd draw -> no o_Valid, o_Busy stays 0;
- i_Shuffle -> o_Remaining=52, o_Empty=0.
REQ-023 i_Shuffle and i_Draw in the same IDLE cycle -> deck refilled, no deal.
REQ-024 i_Reset asserted while in DELAY -> next cycle o_TwoSec=0, o_Busy=0, o_Remaining=52, and no o_Valid follows.
